dc_mcl_layer_config_manager: RTL
================================

DC_MCL_LAYER_CONFIG_MANAGER -- requirements
Module: dc_mcl_layer_config_manager

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, number of layers configured per request (1..8).
REQ-002 SHALL have parameters SCR_SIZE_WIDTH (12), AXI_ARADDR_WIDTH (32), RGB_WIDTH (24), SCALE_METHOD_WIDTH (2), UNDERRUN_CNT_WIDTH (8); LIDX_W = max(1, clog2(NUM_LAYERS)).
REQ-003 SHALL have clk, input, 1, clock; nrst, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have en, input, 1, global enable: low freezes all state and outputs.
REQ-005 SHALL have sw_layer_pos, input, 3*NUM_LAYERS, position code per layer (layer i at bits [3i+2:3i]).
REQ-006 SHALL have sw_layer_scaling, input, 3*NUM_LAYERS, scaling code per layer; sw_scaling_method, input, SCALE_METHOD_WIDTH.
REQ-007 SHALL have const_input_size_width/height and const_output_size_width/height, input, SCR_SIZE_WIDTH each.
REQ-008 SHALL have const_layer_address, input, AXI_ARADDR_WIDTH*NUM_LAYERS; const_border_color, input, RGB_WIDTH.
REQ-009 SHALL have user_int_valid input 1 and user_int_ready output 1 (request handshake); underrun, frame_finished, input, 1 each.
REQ-010 SHALL have outputs conf_image_offset_x/y, conf_image_width/height, conf_screen_width/height, conf_tex_width/height (SCR_SIZE_WIDTH), conf_scale_method, conf_border_color, conf_tex_address, conf_layer_idx (LIDX_W), conf_last (1), conf_valid (1); conf_ready input 1.
REQ-011 SHALL have outputs led_frame_underrun (1), led_frame_finished (1), underrun_cnt (UNDERRUN_CNT_WIDTH).

Function
REQ-012 SHALL implement FSM IDLE, CALC, SEND; user_int_ready = (state==IDLE).
REQ-013 IDLE: on user_int_valid, SHALL snapshot all sw_* inputs, set layer index to 0, go CALC.
REQ-014 CALC: SHALL register geometry for current layer into conf_* outputs, go SEND (exactly 1 cycle).
REQ-015 SEND: conf_valid=1; all conf_* SHALL stay stable until conf_ready; on conf_valid&&conf_ready: if index==NUM_LAYERS-1 go IDLE, else index+1 and go CALC.
REQ-016 conf_last SHALL be 1 iff conf_layer_idx==NUM_LAYERS-1; latency request-accept to first conf_valid = 2 cycles.
REQ-017 Scaling code -> image dim: 000 input; 001 output (fullscreen); 010 input<<2; 011 input<<1; 100 input>>1; 101 input>>2; 110/111 input.
REQ-018 Scaled dims SHALL be computed at SCR_SIZE_WIDTH+2 bits and saturated to the output dimension (never exceed screen).
REQ-019 Position code -> offset: 000 TL (0,0); 001 TR; 010 BL; 011 BR (right/bottom = screen-image); 100 centre ((screen>>1)-(image>>1)); 101-111 hidden (offset = screen dim).
REQ-020 Fullscreen (001) SHALL force offsets 0 regardless of position code.
REQ-021 conf_tex_address SHALL be the current layer's const_layer_address slice; screen/tex dims, border colour, scale method copied from inputs/snapshot.
REQ-022 underrun_cnt SHALL count cycles with underrun=1, saturate at all-ones, clear when a request is accepted in IDLE (accept wins over simultaneous underrun).
REQ-023 led_frame_underrun SHALL be sticky (set by underrun, cleared on request accept); led_frame_finished = frame_finished (combinational).
REQ-024 Switch changes after snapshot SHALL NOT affect the sequence in flight; user_int_valid outside IDLE SHALL be ignored.
REQ-025 en low SHALL hold state, index, counters and outputs, including during SEND (conf_valid held, handshake not counted).

Reset
REQ-026 nrst low SHALL asynchronously force state IDLE, index 0, all conf_* outputs, conf_valid, conf_last, underrun_cnt, led_frame_underrun to 0; user_int_ready=1 after reset.
REQ-027 Reset mid-sequence SHALL abort it; no partial layer resumes.

Structure
REQ-028 FSM state enum, scaling and position code constants SHALL live in shared package dc_mcl_pkg.
REQ-029 Per-layer geometry (REQ-017..020) SHALL be a combinational sub-module dc_mcl_layer_geom, instantiated once and fed by muxed current-layer inputs.

Verification
REQ-030 In 640x480, out 1920x1080, NUM_LAYERS=2, L0 scale 000 pos 000, L1 scale 011 pos 011 -> L0 (0,0,640,480), L1 (640,120,1280,960), conf_last on L1 only.
REQ-031 L0 scale 010 pos 100 -> width 2560 saturated to 1920, height 1080, offset (0,0).
REQ-032 conf_ready held low 5 cycles in SEND -> conf_valid and all conf_* stable; layer advances only on ready.
REQ-033 300 underrun cycles with 8-bit counter -> underrun_cnt=255, LED sticky; next request accept -> both 0.
REQ-034 Toggle en low during SEND and nrst low during L1 CALC -> hold behaviour, then full reset values and IDLE.
REQ-035 L0 scale 001 pos 101 -> offset (0,0), size 1920x1080.

Source files
------------

// File: rtl/dc_mcl_pkg.sv
// Shared types and code points for the display-controller layer configuration path.
// Holds the sequencer state encoding and the scaling/position code constants.
package dc_mcl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } mcl_state_e;

    localparam logic [2:0] SCALE_NONE    = 3'b000;
    localparam logic [2:0] SCALE_FULL    = 3'b001;
    localparam logic [2:0] SCALE_X4      = 3'b010;
    localparam logic [2:0] SCALE_X2      = 3'b011;
    localparam logic [2:0] SCALE_HALF    = 3'b100;
    localparam logic [2:0] SCALE_QUARTER = 3'b101;

    localparam logic [2:0] POS_TL     = 3'b000;
    localparam logic [2:0] POS_TR     = 3'b001;
    localparam logic [2:0] POS_BL     = 3'b010;
    localparam logic [2:0] POS_BR     = 3'b011;
    localparam logic [2:0] POS_CENTRE = 3'b100;

    function automatic int lidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dc_mcl_layer_geom.sv
// Combinational per-layer geometry: scaled image size clamped to the screen,
// and the placement offset derived from the position code.
module dc_mcl_layer_geom
    import dc_mcl_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] in_w,
    input  logic [W-1:0] in_h,
    input  logic [W-1:0] out_w,
    input  logic [W-1:0] out_h,
    input  logic [2:0]   scale,
    input  logic [2:0]   pos,
    output logic [W-1:0] img_w,
    output logic [W-1:0] img_h,
    output logic [W-1:0] off_x,
    output logic [W-1:0] off_y
);

    logic [W+1:0] wide_w_s;
    logic [W+1:0] wide_h_s;

    // Two guard bits keep x4 upscaling exact before the clamp.
    function automatic logic [W+1:0] scale_dim(input logic [W-1:0] in_d,
                                               input logic [W-1:0] out_d,
                                               input logic [2:0]   code);
        logic [W+1:0] v;
        case (code)
            SCALE_NONE:    v = {2'b00, in_d};
            SCALE_FULL:    v = {2'b00, out_d};
            SCALE_X4:      v = {in_d, 2'b00};
            SCALE_X2:      v = {1'b0, in_d, 1'b0};
            SCALE_HALF:    v = {3'b000, in_d[W-1:1]};
            SCALE_QUARTER: v = {4'b0000, in_d[W-1:2]};
            default:       v = {2'b00, in_d};
        endcase
        return v;
    endfunction

    // Scaled size, saturated so the image never exceeds the screen.
    always_comb begin
        wide_w_s = scale_dim(in_w, out_w, scale);
        wide_h_s = scale_dim(in_h, out_h, scale);
        if (wide_w_s > {2'b00, out_w}) begin
            img_w = out_w;
        end else begin
            img_w = wide_w_s[W-1:0];
        end
        if (wide_h_s > {2'b00, out_h}) begin
            img_h = out_h;
        end else begin
            img_h = wide_h_s[W-1:0];
        end
    end

    // Placement offset; a fullscreen layer is always anchored at the origin.
    always_comb begin
        off_x = '0;
        off_y = '0;
        if (scale == SCALE_FULL) begin
            off_x = '0;
            off_y = '0;
        end else begin
            case (pos)
                POS_TL:     begin off_x = '0;                           off_y = '0;                           end
                POS_TR:     begin off_x = out_w - img_w;                off_y = '0;                           end
                POS_BL:     begin off_x = '0;                           off_y = out_h - img_h;                end
                POS_BR:     begin off_x = out_w - img_w;                off_y = out_h - img_h;                end
                POS_CENTRE: begin off_x = (out_w >> 1) - (img_w >> 1); off_y = (out_h >> 1) - (img_h >> 1); end
                default:    begin off_x = out_w;                        off_y = out_h;                        end
            endcase
        end
    end

endmodule

// File: rtl/dc_mcl_layer_config_manager.sv
// Layer configuration sequencer: snapshots the switch settings on a request and
// emits one registered configuration record per layer over a valid/ready port.
module dc_mcl_layer_config_manager
    import dc_mcl_pkg::*;
#(
    parameter int NUM_LAYERS         = 2,
    parameter int SCR_SIZE_WIDTH     = 12,
    parameter int AXI_ARADDR_WIDTH   = 32,
    parameter int RGB_WIDTH          = 24,
    parameter int SCALE_METHOD_WIDTH = 2,
    parameter int UNDERRUN_CNT_WIDTH = 8,
    localparam int LIDX_W            = lidx_width(NUM_LAYERS)
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic                                   en,
    input  logic [3*NUM_LAYERS-1:0]                sw_layer_pos,
    input  logic [3*NUM_LAYERS-1:0]                sw_layer_scaling,
    input  logic [SCALE_METHOD_WIDTH-1:0]          sw_scaling_method,
    input  logic [SCR_SIZE_WIDTH-1:0]              const_input_size_width,
    input  logic [SCR_SIZE_WIDTH-1:0]              const_input_size_height,
    input  logic [SCR_SIZE_WIDTH-1:0]              const_output_size_width,
    input  logic [SCR_SIZE_WIDTH-1:0]              const_output_size_height,
    input  logic [AXI_ARADDR_WIDTH*NUM_LAYERS-1:0] const_layer_address,
    input  logic [RGB_WIDTH-1:0]                   const_border_color,
    input  logic                                   user_int_valid,
    output logic                                   user_int_ready,
    input  logic                                   underrun,
    input  logic                                   frame_finished,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_image_offset_x,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_image_offset_y,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_image_width,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_image_height,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_screen_width,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_screen_height,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_tex_width,
    output logic [SCR_SIZE_WIDTH-1:0]              conf_tex_height,
    output logic [SCALE_METHOD_WIDTH-1:0]          conf_scale_method,
    output logic [RGB_WIDTH-1:0]                   conf_border_color,
    output logic [AXI_ARADDR_WIDTH-1:0]            conf_tex_address,
    output logic [LIDX_W-1:0]                      conf_layer_idx,
    output logic                                   conf_last,
    output logic                                   conf_valid,
    input  logic                                   conf_ready,
    output logic                                   led_frame_underrun,
    output logic                                   led_frame_finished,
    output logic [UNDERRUN_CNT_WIDTH-1:0]          underrun_cnt
);

    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [UNDERRUN_CNT_WIDTH-1:0] CNT_MAX = {UNDERRUN_CNT_WIDTH{1'b1}};

    mcl_state_e                        state_r;
    mcl_state_e                        next_state_s;
    logic [LIDX_W-1:0]                 layer_idx_r;
    logic [3*NUM_LAYERS-1:0]           sw_pos_r;
    logic [3*NUM_LAYERS-1:0]           sw_scal_r;
    logic [SCALE_METHOD_WIDTH-1:0]     sw_method_r;
    logic                              accept_s;
    logic                              handshake_s;
    logic                              last_s;
    logic [2:0]                        cur_pos_s;
    logic [2:0]                        cur_scal_s;
    logic [AXI_ARADDR_WIDTH-1:0]       cur_addr_s;
    logic [SCR_SIZE_WIDTH-1:0]         geom_w_s;
    logic [SCR_SIZE_WIDTH-1:0]         geom_h_s;
    logic [SCR_SIZE_WIDTH-1:0]         geom_x_s;
    logic [SCR_SIZE_WIDTH-1:0]         geom_y_s;
    logic [UNDERRUN_CNT_WIDTH-1:0]     underrun_cnt_r;
    logic                              led_underrun_r;

    assign accept_s    = en && (state_r == ST_IDLE) && user_int_valid;
    assign handshake_s = en && (state_r == ST_SEND) && conf_ready;
    assign last_s      = (layer_idx_r == LAST_IDX);
    assign cur_pos_s   = sw_pos_r[3*int'(layer_idx_r) +: 3];
    assign cur_scal_s  = sw_scal_r[3*int'(layer_idx_r) +: 3];
    assign cur_addr_s  = const_layer_address[AXI_ARADDR_WIDTH*int'(layer_idx_r) +: AXI_ARADDR_WIDTH];

    dc_mcl_layer_geom #(
        .W (SCR_SIZE_WIDTH)
    ) u_geom (
        .in_w  (const_input_size_width),
        .in_h  (const_input_size_height),
        .out_w (const_output_size_width),
        .out_h (const_output_size_height),
        .scale (cur_scal_s),
        .pos   (cur_pos_s),
        .img_w (geom_w_s),
        .img_h (geom_h_s),
        .off_x (geom_x_s),
        .off_y (geom_y_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else if (en) begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (user_int_valid) next_state_s = ST_CALC;
                else                next_state_s = ST_IDLE;
            end
            ST_CALC: next_state_s = ST_SEND;
            ST_SEND: begin
                if (conf_ready) next_state_s = last_s ? ST_IDLE : ST_CALC;
                else            next_state_s = ST_SEND;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        user_int_ready = (state_r == ST_IDLE);
        conf_valid     = (state_r == ST_SEND);
    end

    // Switch snapshot, layer index and the registered configuration record.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            layer_idx_r         <= '0;
            sw_pos_r            <= '0;
            sw_scal_r           <= '0;
            sw_method_r         <= '0;
            conf_image_offset_x <= '0;
            conf_image_offset_y <= '0;
            conf_image_width    <= '0;
            conf_image_height   <= '0;
            conf_screen_width   <= '0;
            conf_screen_height  <= '0;
            conf_tex_width      <= '0;
            conf_tex_height     <= '0;
            conf_scale_method   <= '0;
            conf_border_color   <= '0;
            conf_tex_address    <= '0;
            conf_layer_idx      <= '0;
            conf_last           <= 1'b0;
        end else if (en) begin
            if (accept_s) begin
                sw_pos_r    <= sw_layer_pos;
                sw_scal_r   <= sw_layer_scaling;
                sw_method_r <= sw_scaling_method;
                layer_idx_r <= '0;
            end else if (handshake_s && !last_s) begin
                layer_idx_r <= layer_idx_r + LIDX_W'(1);
            end
            if (state_r == ST_CALC) begin
                conf_image_offset_x <= geom_x_s;
                conf_image_offset_y <= geom_y_s;
                conf_image_width    <= geom_w_s;
                conf_image_height   <= geom_h_s;
                conf_screen_width   <= const_output_size_width;
                conf_screen_height  <= const_output_size_height;
                conf_tex_width      <= const_input_size_width;
                conf_tex_height     <= const_input_size_height;
                conf_scale_method   <= sw_method_r;
                conf_border_color   <= const_border_color;
                conf_tex_address    <= cur_addr_s;
                conf_layer_idx      <= layer_idx_r;
                conf_last           <= last_s;
            end
        end
    end

    // Underrun statistics; a request accept clears them and wins over a new underrun.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            underrun_cnt_r <= '0;
            led_underrun_r <= 1'b0;
        end else if (en) begin
            if (accept_s) begin
                underrun_cnt_r <= '0;
                led_underrun_r <= 1'b0;
            end else if (underrun) begin
                led_underrun_r <= 1'b1;
                if (underrun_cnt_r != CNT_MAX) underrun_cnt_r <= underrun_cnt_r + UNDERRUN_CNT_WIDTH'(1);
            end
        end
    end

    assign underrun_cnt       = underrun_cnt_r;
    assign led_frame_underrun = led_underrun_r;
    assign led_frame_finished = frame_finished;

endmodule
